// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: walks the datapath through the initial
// approximation, ITERATIONS N/D refinement pairs and the remainder step,
// then holds result_valid until the consumer acknowledges.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; only state that accepts a command
// INIT_D | regC = d*ia, regA = ~(d*ia)
// INIT_X | regB = x*ia
// MUL_N  | regB = regA*regB (numerator update)
// MUL_D  | regC = regA*regC, regA = ~regC (denominator update)
// REM    | regR = d*Q
// DONE   | result held, waiting for out_ack
module fpdiv_ctrl #(
   parameter int ITERATIONS = 3,
   parameter int CNT_W      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             special,
   input  logic             abort,
   input  logic             out_ack,
   output logic             start_ready,
   output logic             busy,
   output logic [1:0]       sel_muxa,
   output logic [1:0]       sel_muxb,
   output logic             enA,
   output logic             enB,
   output logic             enC,
   output logic             enR,
   output logic             result_valid,
   output logic             special_flag,
   output logic [CNT_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT_D = 3'd1,
      INIT_X = 3'd2,
      MUL_N  = 3'd3,
      MUL_D  = 3'd4,
      REM    = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t state, state_nx;

   logic       busy_s;
   logic       last_pair;
   logic       en_ac_raw, en_b_raw, en_r_raw;

   // Extra bit keeps the compare exact even when iter_cnt is at its maximum.
   assign last_pair = (({1'b0, iter_cnt} + {{CNT_W{1'b0}}, 1'b1})
                       == (CNT_W+1)'(ITERATIONS));

   // State register plus the per-operation iteration count and special flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         iter_cnt     <= '0;
         special_flag <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            iter_cnt     <= '0;
            special_flag <= special;
         end else if (busy_s && abort) begin
            iter_cnt     <= '0;
            special_flag <= 1'b0;
         end else if (state == MUL_D && iter_cnt != CNT_W'(ITERATIONS)) begin
            iter_cnt <= iter_cnt + 1'b1;
         end
      end
   end

   // Next-state decode and Moore outputs; abort gates the enables in-cycle.
   always_comb begin
      state_nx     = state;
      busy_s       = 1'b0;
      start_ready  = 1'b0;
      result_valid = 1'b0;
      sel_muxa     = 2'b00;
      sel_muxb     = 2'b00;
      en_ac_raw    = 1'b0;
      en_b_raw     = 1'b0;
      en_r_raw     = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start) state_nx = special ? DONE : INIT_D;
         end
         INIT_D: begin
            busy_s    = 1'b1;
            sel_muxa  = 2'b10;
            sel_muxb  = 2'b00;
            en_ac_raw = 1'b1;
            state_nx  = INIT_X;
         end
         INIT_X: begin
            busy_s   = 1'b1;
            sel_muxa = 2'b10;
            sel_muxb = 2'b01;
            en_b_raw = 1'b1;
            state_nx = MUL_N;
         end
         MUL_N: begin
            busy_s   = 1'b1;
            sel_muxa = 2'b00;
            sel_muxb = 2'b10;
            en_b_raw = 1'b1;
            state_nx = MUL_D;
         end
         MUL_D: begin
            busy_s    = 1'b1;
            sel_muxa  = 2'b00;
            sel_muxb  = 2'b11;
            en_ac_raw = 1'b1;
            state_nx  = last_pair ? REM : MUL_N;
         end
         REM: begin
            busy_s   = 1'b1;
            sel_muxa = 2'b01;
            sel_muxb = 2'b10;
            en_r_raw = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            if (out_ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (busy_s && abort) state_nx = IDLE;
      busy = busy_s;
      enA  = en_ac_raw & ~abort;
      enC  = en_ac_raw & ~abort;
      enB  = en_b_raw  & ~abort;
      enR  = en_r_raw  & ~abort;
   end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: per-cycle output trace against a table of
// expected state outputs, special bypass, abort, ignored start/ack, async reset.
module tb_fpdiv_ctrl;

   localparam int NITER = 3;
   localparam int CW    = 4;

   // Bench-side state labels, independent of the RTL encoding.
   localparam int S_IDLE = 0, S_INIT_D = 1, S_INIT_X = 2, S_MUL_N = 3,
                  S_MUL_D = 4, S_REM = 5, S_DONE = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0, special = 1'b0, abort = 1'b0, out_ack = 1'b0;
   logic          start_ready, busy, enA, enB, enC, enR, result_valid, special_flag;
   logic [1:0]    sel_muxa, sel_muxb;
   logic [CW-1:0] iter_cnt;

   int checks   = 0;
   int failures = 0;

   fpdiv_ctrl #(.ITERATIONS(NITER), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .special(special),
      .abort(abort), .out_ack(out_ack), .start_ready(start_ready), .busy(busy),
      .sel_muxa(sel_muxa), .sel_muxb(sel_muxb), .enA(enA), .enB(enB),
      .enC(enC), .enR(enR), .result_valid(result_valid),
      .special_flag(special_flag), .iter_cnt(iter_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {start_ready, busy, muxa, muxb, enA, enB, enC, enR, result_valid}
   function automatic logic [10:0] exp_out(input int st, input bit gated);
      logic [10:0] v;
      case (st)
         S_IDLE:   v = 11'b1_0_00_00_0000_0;
         S_INIT_D: v = 11'b0_1_10_00_1010_0;
         S_INIT_X: v = 11'b0_1_10_01_0100_0;
         S_MUL_N:  v = 11'b0_1_00_10_0100_0;
         S_MUL_D:  v = 11'b0_1_00_11_1010_0;
         S_REM:    v = 11'b0_1_01_10_0001_0;
         S_DONE:   v = 11'b0_0_00_00_0000_1;
         default:  v = '0;
      endcase
      if (gated) v[4:1] = 4'b0000;
      return v;
   endfunction

   function automatic logic [10:0] obs_out();
      return {start_ready, busy, sel_muxa, sel_muxb, enA, enB, enC, enR, result_valid};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_st(input string tag, input int st, input int it);
      check({tag, "_out"}, 32'(obs_out()), 32'(exp_out(st, 1'b0)));
      check({tag, "_iter"}, 32'(iter_cnt), 32'(it));
   endtask

   task automatic issue(input logic sp);
      start   = 1'b1;
      special = sp;
      step();
      start   = 1'b0;
      special = 1'b0;
   endtask

   // Walks from INIT_D to DONE (or stops in REM), optionally poking start in MUL_D.
   task automatic run_seq(input string tag, input bit pulse, input bit stop_rem);
      expect_st({tag, "_init_d"}, S_INIT_D, 0);
      step();
      expect_st({tag, "_init_x"}, S_INIT_X, 0);
      step();
      for (int i = 0; i < NITER; i++) begin
         expect_st($sformatf("%s_mul_n%0d", tag, i), S_MUL_N, i);
         step();
         expect_st($sformatf("%s_mul_d%0d", tag, i), S_MUL_D, i);
         if (pulse && i == 0) start = 1'b1;
         step();
         start = 1'b0;
      end
      expect_st({tag, "_rem"}, S_REM, NITER);
      if (!stop_rem) begin
         step();
         expect_st({tag, "_done"}, S_DONE, NITER);
      end
   endtask

   initial begin
      #12;
      expect_st("rst", S_IDLE, 0);
      check("rst_flag", 32'(special_flag), 0);
      reset = 1'b1;
      step();
      expect_st("idle", S_IDLE, 0);

      // Normal op with a stray start in MUL_D; DONE holds; ack+start together.
      issue(1'b0);
      run_seq("n1", 1'b1, 1'b0);
      check("n1_flag", 32'(special_flag), 0);
      step();
      expect_st("n1_hold1", S_DONE, NITER);
      abort = 1'b1;
      step();
      abort = 1'b0;
      expect_st("n1_abort_done", S_DONE, NITER);
      out_ack = 1'b1;
      start   = 1'b1;
      step();
      out_ack = 1'b0;
      start   = 1'b0;
      expect_st("n1_ack", S_IDLE, NITER);
      step();
      expect_st("n1_idle2", S_IDLE, NITER);
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      expect_st("ack_in_idle", S_IDLE, NITER);

      // Special operand bypasses iteration.
      issue(1'b1);
      expect_st("sp_done", S_DONE, 0);
      check("sp_flag", 32'(special_flag), 1);
      step();
      expect_st("sp_hold", S_DONE, 0);
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      expect_st("sp_idle", S_IDLE, 0);

      // Abort in the second MUL_N.
      issue(1'b0);
      check("ab_flag_clr", 32'(special_flag), 0);
      expect_st("ab_init_d", S_INIT_D, 0);
      step();
      expect_st("ab_init_x", S_INIT_X, 0);
      step();
      expect_st("ab_mul_n0", S_MUL_N, 0);
      step();
      expect_st("ab_mul_d0", S_MUL_D, 0);
      step();
      expect_st("ab_mul_n1", S_MUL_N, 1);
      abort = 1'b1;
      #1;
      check("ab_gated", 32'(obs_out()), 32'(exp_out(S_MUL_N, 1'b1)));
      step();
      abort = 1'b0;
      expect_st("ab_idle", S_IDLE, 0);
      step();
      expect_st("ab_idle2", S_IDLE, 0);
      issue(1'b0);
      run_seq("n2", 1'b0, 1'b0);
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      expect_st("n2_idle", S_IDLE, NITER);

      // Asynchronous reset between edges while in REM.
      issue(1'b0);
      run_seq("rs", 1'b0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      expect_st("rs_async", S_IDLE, 0);
      #2;
      reset = 1'b1;
      step();
      expect_st("rs_release", S_IDLE, 0);
      step();
      expect_st("rs_idle2", S_IDLE, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
